// File: rtl/seq_detect_if.sv
// Configuration, stream and status bundle between the sequence detector and its
// controller. The controller side drives pattern writes, the stream and the
// enables; the detector side returns the stage, status code and match event.
interface seq_detect_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 8
);
   localparam int AW = $clog2(DEPTH + 1);

   logic              en;
   logic              cfg_we;
   logic [AW-1:0]     cfg_addr;
   logic [DATA_W-1:0] cfg_data;
   logic              cnt_clr;
   logic              in_valid;
   logic [DATA_W-1:0] in_val;
   logic [DATA_W-1:0] out_val;
   logic [AW-1:0]     stage;
   logic              match;
   logic [CNT_W-1:0]  match_cnt;

   modport master (
      output en, cfg_we, cfg_addr, cfg_data, cnt_clr, in_valid, in_val,
      input  out_val, stage, match, match_cnt
   );

   modport slave (
      input  en, cfg_we, cfg_addr, cfg_data, cnt_clr, in_valid, in_val,
      output out_val, stage, match, match_cnt
   );
endinterface

// File: rtl/seq_detect_fsm.sv
// Programmable multi-stage sequence detector. Stages 0..DEPTH-1 track progress
// through a run-time loaded symbol sequence; stage DEPTH (LOCKED) is held while
// the hold symbol keeps arriving. A miss restarts at stage 1 when the symbol
// equals the first pattern symbol. Entry to LOCKED pulses match and bumps a
// saturating counter. The status code is a registered image of the stage.
module seq_detect_fsm #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 8
) (
   input logic         clk,
   input logic         rst,
   seq_detect_if.slave bus
);
   localparam int               AW       = $clog2(DEPTH + 1);
   localparam logic [AW-1:0]    LOCKED   = AW'(DEPTH);
   localparam logic [AW-1:0]    PRE_LOCK = AW'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [AW-1:0]     stage_q, stage_d;
   logic [DATA_W-1:0] out_val_q, out_val_d;
   logic              match_q, match_d;
   logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
   // Slots 0..DEPTH-1 hold the sequence, slot DEPTH holds the LOCKED hold symbol.
   logic [DATA_W-1:0] pat_q [DEPTH+1];
   logic [DATA_W-1:0] pat_d [DEPTH+1];
   logic              hit;
   logic              restart;

   // Next-state, event, counter, status-code and pattern-write logic.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the block can infer a latch.
      stage_d     = stage_q;
      match_d     = 1'b0;
      match_cnt_d = match_cnt_q;
      pat_d       = pat_q;

      // In LOCKED the current-stage slot is the hold symbol, so one compare covers both cases.
      hit     = bus.in_valid && (bus.in_val == pat_q[stage_q]);
      restart = (bus.in_val == pat_q[0]);

      if (!bus.en) begin
         stage_d = '0;
      end else if (!bus.in_valid) begin
         stage_d = stage_q;
      end else if (hit) begin
         stage_d = (stage_q == LOCKED) ? LOCKED : stage_q + AW'(1);
      end else if (restart) begin
         stage_d = AW'(1);
      end else begin
         stage_d = '0;
      end

      // Only the DEPTH-1 -> DEPTH step counts as an entry; a LOCKED->1 restart with DEPTH=1 does not.
      match_d = (stage_q == PRE_LOCK) && (stage_d == LOCKED);

      if (bus.cnt_clr) begin
         match_cnt_d = '0;
      end else if (match_d && (match_cnt_q != CNT_MAX)) begin
         match_cnt_d = match_cnt_q + CNT_W'(1);
      end

      out_val_d = (stage_q == '0) ? DATA_W'(1) : (DATA_W'(1) | (DATA_W'(1) << stage_q));

      if (bus.cfg_we && (bus.cfg_addr <= LOCKED)) begin
         pat_d[bus.cfg_addr] = bus.cfg_data;
      end
   end

   // State register with synchronous reset of every flop, including the pattern slots.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values, independent of statement order.
      if (rst) begin
         stage_q     <= '0;
         out_val_q   <= '0;
         match_q     <= 1'b0;
         match_cnt_q <= '0;
         // NOTE: the pattern store is cleared on reset on purpose; software reloads it after every reset.
         for (int i = 0; i <= DEPTH; i++) begin
            pat_q[i] <= '0;
         end
      end else begin
         stage_q     <= stage_d;
         out_val_q   <= out_val_d;
         match_q     <= match_d;
         match_cnt_q <= match_cnt_d;
         pat_q       <= pat_d;
      end
   end

   assign bus.stage     = stage_q;
   assign bus.out_val   = out_val_q;
   assign bus.match     = match_q;
   assign bus.match_cnt = match_cnt_q;
endmodule

// File: tb/tb_seq_detect_fsm.sv
// Self-checking bench for seq_detect_fsm: directed scenarios plus a randomized
// run, all compared against a behavioural model of the detector rules.
module tb_seq_detect_fsm;
   localparam int DATA_W  = 8;
   localparam int DEPTH   = 4;
   localparam int CNT_W   = 2;
   localparam int AW      = $clog2(DEPTH + 1);
   localparam int OBS_W   = AW + DATA_W + 1 + CNT_W;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Behavioural model state
   int m_stage;
   int m_out;
   bit m_match;
   int m_cnt;
   int m_pat [DEPTH+1];

   seq_detect_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   seq_detect_fsm #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   // Apply one clock edge of the detector rules to the model, from the driven inputs.
   function automatic void model_step();
      int nxt;
      bit entered;
      int addr;
      if (rst) begin
         m_stage = 0; m_out = 0; m_match = 0; m_cnt = 0;
         foreach (m_pat[i]) m_pat[i] = 0;
         return;
      end
      if (!bus.en)                          nxt = 0;
      else if (!bus.in_valid)               nxt = m_stage;
      else if (int'(bus.in_val) == m_pat[m_stage])
                                            nxt = (m_stage == DEPTH) ? DEPTH : m_stage + 1;
      else if (int'(bus.in_val) == m_pat[0]) nxt = 1;
      else                                  nxt = 0;
      entered = (m_stage == DEPTH - 1) && (nxt == DEPTH);
      m_out   = (m_stage == 0) ? 1 : 1 + (2 ** m_stage);
      m_match = entered;
      if (bus.cnt_clr)   m_cnt = 0;
      else if (entered)  m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      addr = int'(bus.cfg_addr);
      if (bus.cfg_we && addr <= DEPTH) m_pat[addr] = int'(bus.cfg_data);
      m_stage = nxt;
   endfunction

   function automatic logic [OBS_W-1:0] exp_vec();
      return {AW'(m_stage), DATA_W'(m_out), m_match, CNT_W'(m_cnt)};
   endfunction

   function automatic logic [OBS_W-1:0] obs_vec();
      return {bus.stage, bus.out_val, bus.match, bus.match_cnt};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic sym(input int v);
      bus.in_valid = 1'b1;
      bus.in_val   = DATA_W'(v);
      tick();
   endtask

   task automatic gap();
      bus.in_valid = 1'b0;
      tick();
   endtask

   task automatic cfg_write(input int addr, input int data);
      bus.in_valid = 1'b0;
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = AW'(addr);
      bus.cfg_data = DATA_W'(data);
      tick();
      bus.cfg_we   = 1'b0;
   endtask

   task automatic load_pats();
      cfg_write(0, 'h81); cfg_write(1, 'h42); cfg_write(2, 'h24);
      cfg_write(3, 'h18); cfg_write(4, 'h1C);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.en = 1'b1; bus.in_valid = 1'b1; bus.in_val = 8'h81; bus.cnt_clr = 1'b0;
      bus.cfg_we = 1'b1; bus.cfg_addr = '0; bus.cfg_data = 8'h81;
      tick(); tick();
      n_tests++;
      if (obs_vec() !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got %h want 0", obs_vec());
      end
      rst = 1'b0; bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
      tick();
      n_tests++;
      if (bus.out_val !== 8'h01 || bus.stage !== '0) begin
         n_fail++;
         $display("FAIL reset_idle_code: got out_val=%h stage=%0d want 01/0", bus.out_val, bus.stage);
      end
   endtask

   task automatic test_lock();
      int vals      [7] = '{'h81, 'h42, 'h24, 'h18, 'h1C, 'h1C, 'h00};
      int exp_stage [7] = '{1, 2, 3, 4, 4, 4, 0};
      int exp_out   [7] = '{'h01, 'h03, 'h05, 'h09, 'h11, 'h11, 'h11};
      int exp_match [7] = '{0, 0, 0, 1, 0, 0, 0};
      bus.en = 1'b0;
      load_pats();
      bus.en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         sym(vals[i]);
         n_tests++;
         if (bus.stage !== AW'(exp_stage[i]) || bus.out_val !== DATA_W'(exp_out[i]) ||
             bus.match !== 1'(exp_match[i])) begin
            n_fail++;
            $display("FAIL lock_step%0d: got stage=%0d out=%h match=%b want %0d/%h/%0d",
                     i, bus.stage, bus.out_val, bus.match, exp_stage[i], exp_out[i], exp_match[i]);
         end
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL lock_model%0d: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      n_tests++;
      if (bus.match_cnt !== CNT_W'(1)) begin
         n_fail++;
         $display("FAIL lock_count: got %0d want 1", bus.match_cnt);
      end
   endtask

   task automatic test_restart();
      int vals      [6] = '{'h81, 'h42, 'h81, 'h42, 'h24, 'h18};
      int exp_stage [6] = '{1, 2, 1, 2, 3, 4};
      for (int i = 0; i < 6; i++) begin
         sym(vals[i]);
         n_tests++;
         if (bus.stage !== AW'(exp_stage[i]) || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL restart_step%0d: got stage=%0d obs=%h want stage=%0d obs=%h",
                     i, bus.stage, obs_vec(), exp_stage[i], exp_vec());
         end
      end
      sym('h00);
   endtask

   task automatic test_valid_gap();
      int exp_stage [7] = '{1, 1, 1, 1, 2, 3, 4};
      for (int i = 0; i < 7; i++) begin
         if (i == 0)      sym('h81);
         else if (i < 4)  gap();
         else if (i == 4) sym('h42);
         else if (i == 5) sym('h24);
         else             sym('h18);
         n_tests++;
         if (bus.stage !== AW'(exp_stage[i]) || bus.match !== (i == 6) || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL gap_step%0d: got stage=%0d match=%b obs=%h want stage=%0d match=%0d obs=%h",
                     i, bus.stage, bus.match, obs_vec(), exp_stage[i], (i == 6), exp_vec());
         end
      end
      sym('h00);
   endtask

   task automatic test_saturation();
      int exp_cnt [5] = '{1, 2, 3, 3, 3};
      bus.cnt_clr = 1'b1; gap(); bus.cnt_clr = 1'b0;
      n_tests++;
      if (bus.match_cnt !== '0) begin
         n_fail++;
         $display("FAIL sat_clear: got %0d want 0", bus.match_cnt);
      end
      for (int r = 0; r < 5; r++) begin
         sym('h81); sym('h42); sym('h24); sym('h18); sym('h00);
         n_tests++;
         if (bus.match_cnt !== CNT_W'(exp_cnt[r]) || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL sat_round%0d: got cnt=%0d want %0d", r, bus.match_cnt, exp_cnt[r]);
         end
      end
      sym('h81); sym('h42); sym('h24);
      bus.cnt_clr = 1'b1; sym('h18); bus.cnt_clr = 1'b0;
      n_tests++;
      if (bus.match !== 1'b1 || bus.match_cnt !== '0) begin
         n_fail++;
         $display("FAIL sat_clear_wins: got match=%b cnt=%0d want 1/0", bus.match, bus.match_cnt);
      end
      sym('h00);
   endtask

   task automatic test_reconfig();
      sym('h81); sym('h42);
      cfg_write(2, 'h55);
      n_tests++;
      if (bus.stage !== AW'(2)) begin
         n_fail++;
         $display("FAIL reconfig_hold: got stage=%0d want 2", bus.stage);
      end
      sym('h55);
      n_tests++;
      if (bus.stage !== AW'(3) || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL reconfig_new_symbol: got stage=%0d want 3", bus.stage);
      end
      cfg_write(7, 'hAA);
      sym('h18);
      n_tests++;
      if (bus.stage !== AW'(4) || bus.match !== 1'b1 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL reconfig_bad_addr: got stage=%0d match=%b want 4/1", bus.stage, bus.match);
      end
      cfg_write(2, 'h24);
      sym('h00);
   endtask

   task automatic test_reset_enable();
      int cnt_before;
      sym('h81); sym('h42); sym('h24);
      rst = 1'b1; tick(); rst = 1'b0;
      n_tests++;
      if (obs_vec() !== '0) begin
         n_fail++;
         $display("FAIL midrun_reset: got %h want 0", obs_vec());
      end
      // Cleared slots all read 00, so a run of 00 symbols must walk to LOCKED.
      for (int i = 1; i <= 4; i++) begin
         sym('h00);
         n_tests++;
         if (bus.stage !== AW'(i) || bus.match !== (i == 4) || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL slots_cleared%0d: got stage=%0d match=%b want %0d/%0d",
                     i, bus.stage, bus.match, i, (i == 4));
         end
      end
      sym('h01);
      load_pats();
      sym('h81); sym('h42);
      cnt_before = m_cnt;
      bus.en = 1'b0; sym('h24); bus.en = 1'b1;
      n_tests++;
      if (bus.stage !== '0 || bus.match_cnt !== CNT_W'(cnt_before)) begin
         n_fail++;
         $display("FAIL enable_drop: got stage=%0d cnt=%0d want 0/%0d", bus.stage, bus.match_cnt, cnt_before);
      end
   endtask

   task automatic test_random();
      int syms [5] = '{'h81, 'h42, 'h24, 'h18, 'h1C};
      for (int i = 0; i < 600; i++) begin
         rst          = ($urandom_range(0, 199) == 0);
         bus.en       = ($urandom_range(0, 19) != 0);
         bus.cfg_we   = ($urandom_range(0, 29) == 0);
         bus.cfg_addr = AW'($urandom_range(0, 7));
         bus.cfg_data = DATA_W'(syms[$urandom_range(0, 4)]);
         bus.cnt_clr  = ($urandom_range(0, 24) == 0);
         bus.in_valid = ($urandom_range(0, 4) != 0);
         bus.in_val   = ($urandom_range(0, 4) == 0) ? DATA_W'($urandom_range(0, 255))
                                                    : DATA_W'(m_pat[$urandom_range(0, DEPTH)]);
         tick();
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random_cycle%0d: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      rst = 1'b0; bus.cfg_we = 1'b0; bus.cnt_clr = 1'b0; bus.in_valid = 1'b0;
   endtask

   initial begin
      bus.en = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
      bus.cnt_clr = 1'b0; bus.in_valid = 1'b0; bus.in_val = '0;
      m_stage = 0; m_out = 0; m_match = 0; m_cnt = 0;
      foreach (m_pat[i]) m_pat[i] = 0;
      test_reset();
      test_lock();
      test_restart();
      test_valid_gap();
      test_saturation();
      test_reconfig();
      test_reset_enable();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
